// File: rtl/gpio_out_bridge.sv
// gpio_out_bridge
//   Captures software output events from the processor's gpio2/q outputs into
//   a small first-word-fall-through FIFO and presents them to a sink over a
//   valid/ready handshake. An event is a toggle of gpio2[35]; each event stores
//   {tag = gpio2[27:24], data = gpio2[DW-1:0], q, timestamp}.
//
//   Optional feature macro: GPIO_OUT_BRIDGE_TIMESTAMP_EN
//     defined   : 16-bit free-running cycle counter is stored with each entry
//     undefined : no counter, out_ts tied to zero
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   gpio2      in   [36] processor output bus ([35] toggle, [27:24] tag, [DW-1:0] data)
//   q          in   [8]  processor output byte, sampled with each event
//   out_valid  out  head entry available
//   out_ready  in   sink accepts the head entry
//   out_data   out  [DW] head data
//   out_tag    out  [4]  head tag
//   out_q      out  [8]  head q snapshot
//   out_ts     out  [16] head timestamp (zero when timestamps are disabled)
//   level      out  [AW+1] occupancy 0..DEPTH
//   overflow   out  sticky, set when an event is dropped on a full FIFO
//   ovf_clr    in   synchronous clear of overflow (a same-cycle drop wins)
module gpio_out_bridge #(
  parameter int DW    = 24,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [35:0]   gpio2,
  input  logic [7:0]    q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_tag,
  output logic [7:0]    out_q,
  output logic [15:0]   out_ts,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int LW = AW + 1;

  // Not every gpio2 bit is captured; fold them into one unused sink.
  logic unused_gpio2;
  assign unused_gpio2 = ^gpio2;

  logic          tog_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic [DW-1:0] mem_data [DEPTH];
  logic [3:0]    mem_tag  [DEPTH];
  logic [7:0]    mem_qb   [DEPTH];

  logic evt, full, pop, push, drop;

  assign evt  = gpio2[35] ^ tog_q;
  assign full = (level_q == LW'(DEPTH));
  // out_valid gates the pop, so out_ready is ignored while empty.
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Set has priority over clear.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      tog_q      <= gpio2[35];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= gpio2[DW-1:0];
      mem_tag[wr_ptr_q]  <= gpio2[27:24];
      mem_qb[wr_ptr_q]   <= q;
    end
  end

`ifdef GPIO_OUT_BRIDGE_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] mem_ts [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 16'd1;
  end

  // Entry records the counter value seen in the cycle the event arrives.
  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr_q] <= ts_q;
  end

  assign out_ts = mem_ts[rd_ptr_q];
`else
  assign out_ts = 16'h0000;
`endif

  assign out_valid = (level_q != '0);
  assign out_data  = mem_data[rd_ptr_q];
  assign out_tag   = mem_tag[rd_ptr_q];
  assign out_q     = mem_qb[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_gpio_out_bridge.sv
module tb_gpio_out_bridge;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [35:0]   gpio2;
  logic [7:0]    q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_tag;
  logic [7:0]    out_q;
  logic [15:0]   out_ts;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr;

  int n_chk;
  int n_fail;
  logic tog;

  gpio_out_bridge #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio2     (gpio2),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_q     (out_q),
    .out_ts    (out_ts),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one software event (toggle of gpio2[35]) and let it be captured.
  task automatic send(input logic [23:0] data, input logic [3:0] tg, input logic [7:0] qv);
    tog   = ~tog;
    gpio2 = {tog, 7'b0, tg, data};
    q     = qv;
    tick();
  endtask

  initial begin
    logic [15:0] exp_ts0, exp_ts1;
    n_chk     = 0;
    n_fail    = 0;
    tog       = 1'b0;
    rst       = 1'b0;
    gpio2     = '0;
    q         = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single event
    send(24'hABCDEF, 4'h5, 8'h3C);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hABCDEF);
    chk("single_tag", 32'(out_tag), 32'h5);
    chk("single_q", 32'(out_q), 32'h3C);
    chk("single_level", 32'(level), 32'd1);
    tick();
    chk("hold_data", 32'(out_data), 32'hABCDEF);
    chk("hold_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_valid", 32'(out_valid), 32'd0);
    tick();  // ready high while empty: no underflow
    chk("empty_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Burst of 10 into an 8-deep FIFO
    for (int i = 1; i <= 10; i++) send(24'(i), 4'(i), 8'(i + 8'h40));
    chk("burst_level", 32'(level), 32'd8);
    chk("burst_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      chk("drain_tag", 32'(out_tag), 32'(i));
      chk("drain_q", 32'(out_q), 32'(i + 8'h40));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Full with simultaneous pop
    for (int i = 1; i <= 8; i++) send(24'(8'h10 + i), 4'h1, 8'h00);
    chk("full_level", 32'(level), 32'd8);
    out_ready = 1'b1;
    send(24'd9, 4'h9, 8'h99);
    out_ready = 1'b0;
    chk("fullpop_level", 32'(level), 32'd8);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(out_data), 32'h12);

    // Drop and clear in the same cycle: set wins
    ovf_clr = 1'b1;
    send(24'hFF, 4'hF, 8'hFF);
    chk("race_ovf", 32'(overflow), 32'd1);
    chk("race_level", 32'(level), 32'd8);
    tick();
    ovf_clr = 1'b0;
    chk("race_clear", 32'(overflow), 32'd0);
    for (int j = 2; j <= 8; j++) begin
      chk("order_data", 32'(out_data), 32'(8'h10 + j));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("order_last", 32'(out_data), 32'd9);
    chk("order_last_tag", 32'(out_tag), 32'h9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("order_level", 32'(level), 32'd0);

    // Asynchronous reset mid-operation with level 3 and overflow set
    for (int i = 1; i <= 9; i++) send(24'(i), 4'h2, 8'h00);
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    rst   = 1'b0;
    tog   = 1'b0;
    gpio2 = '0;
    #1;
    chk("async_level", 32'(level), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Timestamps: events in cycles 5 and 9 after release
    repeat (5) tick();
    send(24'h000111, 4'h3, 8'h01);
    repeat (3) tick();
    send(24'h000222, 4'h4, 8'h02);
`ifdef GPIO_OUT_BRIDGE_TIMESTAMP_EN
    exp_ts0 = 16'd5;
    exp_ts1 = 16'd9;
`else
    exp_ts0 = 16'd0;
    exp_ts1 = 16'd0;
`endif
    chk("ts_level", 32'(level), 32'd2);
    chk("ts_data0", 32'(out_data), 32'h111);
    chk("ts_first", 32'(out_ts), 32'(exp_ts0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ts_data1", 32'(out_data), 32'h222);
    chk("ts_second", 32'(out_ts), 32'(exp_ts1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
